dm_bytelane: RTL and testbench
==============================

Name: dm_bytelane

Overview:
Parametrised data memory for the pipelined MIPS CPU that replaces the word-only DM.
- Supports word, halfword and byte loads and stores, with sign or zero extension on loads.
- Detects misaligned and out-of-range accesses and reports them as address exceptions.
- Returns load data after a configurable read latency, using a req/ready handshake.
- Sits in the MEM stage; the stall unit uses busy to freeze the pipeline.

Parameters:
DEPTH_WORDS, 3072, number of 32-bit words stored.
ADDR_BASE, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
READ_LAT, 1, cycles from load acceptance to ready; legal range 1..4.
DISPLAY, 1, when 1, every committed store prints a trace line.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
req  in  1  access request; sampled only while busy=0.
we  in  1  1=store, 0=load; qualified by req.
mode  in  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 reserved.
addr  in  32  byte address.
wdata  in  32  store data; the low half or low byte is used for sub-word stores.
pc  in  32  PC of the instruction, used only for the trace line.
busy  out  1  high while a load is in flight.
ready  out  1  one-cycle pulse that completes an accepted request.
rdata  out  32  extended load data; valid only with ready&~we_q.
exc_adel  out  1  load address exception; valid with ready.
exc_ades  out  1  store address exception; valid with ready.

Behaviour:
Reset (reset=1 at posedge):
- All DEPTH_WORDS words are cleared to 0.
- FSM returns to IDLE; busy=0, ready=0, rdata=0, exc_adel=0, exc_ades=0.
- Reset overrides any in-flight load. No ready is produced for a load aborted by reset.

Address and width rules:
- off = addr - ADDR_BASE; index = off[31:2].
- Out of range when off >= DEPTH_WORDS*4 (unsigned compare).
- Misaligned when:
  - word access and addr[1:0] != 0;
  - halfword access and addr[0] != 0.
- A reserved mode is treated as misaligned.
- bad = out-of-range | misaligned.

FSM states: IDLE, LOAD.
- IDLE, req=0: nothing happens; ready=0 next cycle.
- IDLE, req=1, we=1:
  - good address: byte lanes merged into memory on the same edge; ready=1 next cycle with exc_ades=0.
  - bad address: memory unchanged; ready=1 next cycle with exc_ades=1.
  - Stay in IDLE. A back-to-back req is accepted every cycle.
- IDLE, req=1, we=0, bad address: ready=1 next cycle with exc_adel=1 and rdata=0; stay in IDLE.
- IDLE, req=1, we=0, good address:
  - latch index, mode and addr[1:0]; load cnt=READ_LAT-1;
  - busy=1 from the next cycle; go to LOAD.
- LOAD:
  - req is ignored; no write can occur.
  - cnt decrements each cycle.
  - On the edge where cnt==0: read the word, extend it, drive rdata, pulse ready=1, clear busy, return to IDLE.
  - Result: ready is asserted exactly READ_LAT cycles after the acceptance edge.
  - With READ_LAT=1, busy is high for exactly one cycle, the same cycle as ready... 

Correction to the READ_LAT=1 case: ready rises on the edge after acceptance and busy is never seen high; LOAD is entered only when READ_LAT>1.

Byte lanes (little-endian):
- Half store writes bytes {addr[1]*2+1 : addr[1]*2}.
- Byte store writes byte addr[1:0].
- Other bytes are preserved.

Load extension:
- Signed modes replicate the top bit of the selected half or byte.
- Unsigned modes zero-fill.

Outputs between completions:
- ready is a single-cycle pulse.
- rdata and the exception flags hold their last value while ready=0.

Trace line, printed when DISPLAY=1, only for committed stores:
- format "%d@%h: *%h <= %h" with $time, pc, word-aligned addr, and the merged 32-bit word.

Decomposition:
Shared package dm_pkg holds:
- mode encodings: MODE_W, MODE_H, MODE_HU, MODE_B, MODE_BU;
- FSM state enum: ST_IDLE, ST_LOAD;
- the helper constant for READ_LAT range checking.

Natural sub-module: dm_load_ext, a combinational word/mode/addr[1:0] → extended rdata block that the EX/WB forwarding logic can reuse.

Test Plan:
1. Reset, then load word at 0x0 -> ready after READ_LAT cycles, rdata=0, exc_adel=0.
2. sw 0x8765_4321 @0x10; lb @0x13 -> rdata=0xFFFF_FF87; lbu @0x13 -> 0x0000_0087; lh @0x10 -> 0x0000_4321.
3. sb 0xAB @0x21, then sh 0xCDEF @0x22, then lw @0x20 -> 0xCDEF_AB00; trace prints the merged words.
4. sw @0x6 -> exc_ades=1 and memory unchanged (subsequent lw @0x4 = 0); lh @0x3 -> exc_adel=1, rdata=0; sw @DEPTH_WORDS*4 -> exc_ades=1.
5. READ_LAT=3: lw accepted at cycle t -> busy high for cycles t+1..t+2, ready at t+3; a req at t+1 (we=1) is ignored and memory is unchanged.
6. READ_LAT=3: reset asserted at t+1 during a load -> no ready pulse, busy=0 at t+2, all memory reads back 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the byte-lane data memory: mode encodings, FSM states,
// load context and the address/lane helpers used by the top and its sub-blocks.
package dm_pkg;

    localparam logic [2:0] MODE_W  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_HU = 3'b010;
    localparam logic [2:0] MODE_B  = 3'b011;
    localparam logic [2:0] MODE_BU = 3'b100;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;

    typedef enum logic {ST_IDLE, ST_LOAD} state_e;

    // Everything the extender needs once the address has been accepted.
    typedef struct packed {
        logic [2:0] mode;
        logic [1:0] bo;
    } ld_ctx_t;

    // Reserved modes count as misaligned so they raise an address exception.
    function automatic logic misaligned(input logic [2:0] mode, input logic [1:0] bo);
        case (mode)
            MODE_W:          return bo != 2'b00;
            MODE_H, MODE_HU: return bo[0];
            MODE_B, MODE_BU: return 1'b0;
            default:         return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] mode, input logic [1:0] bo);
        case (mode)
            MODE_W:          return 4'b1111;
            MODE_H, MODE_HU: return bo[1] ? 4'b1100 : 4'b0011;
            MODE_B, MODE_BU: return 4'b0001 << bo;
            default:         return 4'b0000;
        endcase
    endfunction

    // Store data replicated so every enabled lane picks its byte from the same slot.
    function automatic logic [31:0] store_rep(input logic [2:0] mode, input logic [31:0] wdata);
        case (mode)
            MODE_H, MODE_HU: return {2{wdata[15:0]}};
            MODE_B, MODE_BU: return {4{wdata[7:0]}};
            default:         return wdata;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Combinational load extender: selects the addressed half/byte of a memory word
// and sign- or zero-extends it. Reusable by forwarding logic.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  mode,
    input  logic [1:0]  bo,
    output logic [31:0] data
);

    logic [15:0] half;
    logic [7:0]  byt;

    always_comb begin
        half = bo[1] ? word[31:16] : word[15:0];
        case (bo)
            2'd0:    byt = word[7:0];
            2'd1:    byt = word[15:8];
            2'd2:    byt = word[23:16];
            default: byt = word[31:24];
        endcase
        case (mode)
            MODE_W:  data = word;
            MODE_H:  data = {{16{half[15]}}, half};
            MODE_HU: data = {16'h0000, half};
            MODE_B:  data = {{24{byt[7]}}, byt};
            MODE_BU: data = {24'h000000, byt};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dm_bytelane.sv
// MEM-stage data memory with word/half/byte access, address exceptions and a
// configurable load latency signalled through busy/ready.
module dm_bytelane
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 3072,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          READ_LAT    = 1,
    parameter bit          DISPLAY     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        exc_adel,
    output logic        exc_ades
);

    localparam int          IW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
    // LOAD lasts READ_LAT-1 cycles, so the counter starts one below that.
    localparam logic [1:0]  CNT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_lat_chk
        $error("dm_bytelane: READ_LAT out of range");
    end

    logic [31:0]   mem [DEPTH_WORDS];
    state_e        state, state_nx;
    logic [1:0]    cnt;
    ld_ctx_t       ctx;
    logic [IW-1:0] idx_q;

    logic [31:0]   off;
    logic [IW-1:0] idx, rd_idx;
    logic          bad, accept, st_ok, done;
    logic [3:0]    be;
    logic [31:0]   wrep, cur, merged, rd_word, ext;
    ld_ctx_t       rd_ctx;

    assign off    = addr - ADDR_BASE;
    assign idx    = off[IW+1:2];
    assign bad    = (off >= LIMIT) | misaligned(mode, addr[1:0]);
    assign accept = req & (state == ST_IDLE);
    assign st_ok  = accept & we & ~bad;
    assign done   = (state == ST_LOAD) && (cnt == 2'd0);
    assign busy   = (state == ST_LOAD);

    assign be   = byte_en(mode, addr[1:0]);
    assign wrep = store_rep(mode, wdata);
    assign cur  = mem[idx];

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : cur[8*i +: 8];
    end

    // Single-cycle loads read at acceptance; longer ones use the latched context.
    assign rd_idx  = (state == ST_LOAD) ? idx_q : idx;
    assign rd_ctx  = (state == ST_LOAD) ? ctx : '{mode: mode, bo: addr[1:0]};
    assign rd_word = mem[rd_idx];

    dm_load_ext u_ext (
        .word (rd_word),
        .mode (rd_ctx.mode),
        .bo   (rd_ctx.bo),
        .data (ext)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept && !we && !bad && READ_LAT > 1) state_nx = ST_LOAD;
            ST_LOAD: if (cnt == 2'd0) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (st_ok) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ctx      <= '0;
            idx_q    <= '0;
            ready    <= 1'b0;
            rdata    <= '0;
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
        end else begin
            state <= state_nx;
            ready <= 1'b0;
            if (state == ST_LOAD && cnt != 2'd0) cnt <= cnt - 2'd1;
            if (accept) begin
                if (we) begin
                    ready    <= 1'b1;
                    exc_ades <= bad;
                    exc_adel <= 1'b0;
                end else if (bad) begin
                    ready    <= 1'b1;
                    exc_adel <= 1'b1;
                    exc_ades <= 1'b0;
                    rdata    <= '0;
                end else if (READ_LAT == 1) begin
                    ready    <= 1'b1;
                    exc_adel <= 1'b0;
                    exc_ades <= 1'b0;
                    rdata    <= ext;
                end else begin
                    cnt   <= CNT_INIT;
                    ctx   <= '{mode: mode, bo: addr[1:0]};
                    idx_q <= idx;
                end
            end else if (done) begin
                ready    <= 1'b1;
                exc_adel <= 1'b0;
                exc_ades <= 1'b0;
                rdata    <= ext;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (DISPLAY && !reset && st_ok)
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
    end
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
// Directed bench: u0 uses READ_LAT=1 at full depth, u1 uses READ_LAT=3 with a
// small depth for the latency, ignore-while-busy and reset-abort scenarios.
module tb_dm_bytelane;

    logic        clk = 1'b0;
    logic        reset0, req0, we0;
    logic [2:0]  mode0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        busy0, ready0, adel0, ades0;
    logic        reset1, req1, we1;
    logic [2:0]  mode1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        busy1, ready1, adel1, ades1;
    logic [31:0] pc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dm_bytelane #(.DEPTH_WORDS(3072), .ADDR_BASE(32'h0), .READ_LAT(1), .DISPLAY(1'b1)) u0 (
        .clk(clk), .reset(reset0), .req(req0), .we(we0), .mode(mode0), .addr(addr0),
        .wdata(wdata0), .pc(pc), .busy(busy0), .ready(ready0), .rdata(rdata0),
        .exc_adel(adel0), .exc_ades(ades0));

    dm_bytelane #(.DEPTH_WORDS(64), .ADDR_BASE(32'h0), .READ_LAT(3), .DISPLAY(1'b0)) u1 (
        .clk(clk), .reset(reset1), .req(req1), .we(we1), .mode(mode1), .addr(addr1),
        .wdata(wdata1), .pc(pc), .busy(busy1), .ready(ready1), .rdata(rdata1),
        .exc_adel(adel1), .exc_ades(ades1));

    // One request on u0; returns 1 ns after the accepting edge.
    task automatic acc0(input logic w, input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
        req0 = 1'b1; we0 = w; mode0 = m; addr0 = a; wdata0 = d; pc = pc + 32'd4;
        @(posedge clk); #1;
        req0 = 1'b0; we0 = 1'b0;
    endtask

    // Load on u1; waits a bounded number of cycles for ready.
    task automatic ld1(input logic [2:0] m, input logic [31:0] a, output logic [31:0] d, output int lat);
        req1 = 1'b1; we1 = 1'b0; mode1 = m; addr1 = a;
        @(posedge clk); #1;
        req1 = 1'b0;
        lat = 1;
        while (!ready1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        d = rdata1;
    endtask

    task automatic test_reset();
        reset0 = 1'b1; reset1 = 1'b1;
        req0 = 0; we0 = 0; mode0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; mode1 = 0; addr1 = 0; wdata1 = 0; pc = 32'h0040_0000;
        repeat (2) @(posedge clk);
        #1;
        reset0 = 1'b0; reset1 = 1'b0;
        n_chk++;
        if ({busy0, ready0, rdata0, adel0, ades0} !== 36'h0) begin
            n_err++; $display("FAIL reset_u0: got %h want 0", {busy0, ready0, rdata0, adel0, ades0});
        end
        n_chk++;
        if ({busy1, ready1, rdata1, adel1, ades1} !== 36'h0) begin
            n_err++; $display("FAIL reset_u1: got %h want 0", {busy1, ready1, rdata1, adel1, ades1});
        end
        acc0(1'b0, 3'b000, 32'h0, 32'h0);
        n_chk++;
        if (ready0 !== 1'b1 || rdata0 !== 32'h0 || adel0 !== 1'b0 || busy0 !== 1'b0) begin
            n_err++; $display("FAIL lw_after_reset: got rdy=%b rd=%h adel=%b busy=%b want 1 0 0 0", ready0, rdata0, adel0, busy0);
        end
        @(posedge clk); #1;
        n_chk++;
        if (ready0 !== 1'b0) begin
            n_err++; $display("FAIL ready_pulse: got %b want 0", ready0);
        end
    endtask

    task automatic test_load_ext();
        acc0(1'b1, 3'b000, 32'h10, 32'h8765_4321);
        n_chk++;
        if (ready0 !== 1'b1 || ades0 !== 1'b0) begin
            n_err++; $display("FAIL sw_0x10: got rdy=%b ades=%b want 1 0", ready0, ades0);
        end
        acc0(1'b0, 3'b011, 32'h13, 32'h0);
        n_chk++;
        if (rdata0 !== 32'hFFFF_FF87) begin
            n_err++; $display("FAIL lb_0x13: got %h want ffffff87", rdata0);
        end
        acc0(1'b0, 3'b100, 32'h13, 32'h0);
        n_chk++;
        if (rdata0 !== 32'h0000_0087) begin
            n_err++; $display("FAIL lbu_0x13: got %h want 00000087", rdata0);
        end
        acc0(1'b0, 3'b001, 32'h10, 32'h0);
        n_chk++;
        if (rdata0 !== 32'h0000_4321) begin
            n_err++; $display("FAIL lh_0x10: got %h want 00004321", rdata0);
        end
        acc0(1'b0, 3'b001, 32'h12, 32'h0);
        n_chk++;
        if (rdata0 !== 32'hFFFF_8765) begin
            n_err++; $display("FAIL lh_0x12: got %h want ffff8765", rdata0);
        end
        acc0(1'b0, 3'b010, 32'h12, 32'h0);
        n_chk++;
        if (rdata0 !== 32'h0000_8765) begin
            n_err++; $display("FAIL lhu_0x12: got %h want 00008765", rdata0);
        end
    endtask

    task automatic test_lane_merge();
        acc0(1'b1, 3'b011, 32'h21, 32'h1234_56AB);
        acc0(1'b1, 3'b001, 32'h22, 32'h9876_CDEF);
        acc0(1'b0, 3'b000, 32'h20, 32'h0);
        n_chk++;
        if (rdata0 !== 32'hCDEF_AB00) begin
            n_err++; $display("FAIL merge_0x20: got %h want cdefab00", rdata0);
        end
        acc0(1'b1, 3'b100, 32'h20, 32'h0000_0011);
        acc0(1'b0, 3'b000, 32'h20, 32'h0);
        n_chk++;
        if (rdata0 !== 32'hCDEF_AB11) begin
            n_err++; $display("FAIL merge_byte0: got %h want cdefab11", rdata0);
        end
    endtask

    task automatic test_exceptions();
        acc0(1'b1, 3'b000, 32'h6, 32'hFFFF_FFFF);
        n_chk++;
        if (ready0 !== 1'b1 || ades0 !== 1'b1 || adel0 !== 1'b0) begin
            n_err++; $display("FAIL sw_0x6: got rdy=%b ades=%b adel=%b want 1 1 0", ready0, ades0, adel0);
        end
        acc0(1'b0, 3'b000, 32'h4, 32'h0);
        n_chk++;
        if (rdata0 !== 32'h0 || adel0 !== 1'b0 || ades0 !== 1'b0) begin
            n_err++; $display("FAIL lw_0x4_unchanged: got %h adel=%b ades=%b want 0 0 0", rdata0, adel0, ades0);
        end
        acc0(1'b0, 3'b000, 32'h10, 32'h0);
        acc0(1'b0, 3'b001, 32'h3, 32'h0);
        n_chk++;
        if (ready0 !== 1'b1 || adel0 !== 1'b1 || rdata0 !== 32'h0) begin
            n_err++; $display("FAIL lh_0x3: got rdy=%b adel=%b rd=%h want 1 1 0", ready0, adel0, rdata0);
        end
        @(posedge clk); #1;
        n_chk++;
        if (ready0 !== 1'b0 || adel0 !== 1'b1) begin
            n_err++; $display("FAIL flag_hold: got rdy=%b adel=%b want 0 1", ready0, adel0);
        end
        acc0(1'b1, 3'b000, 32'h3000, 32'h5555_5555);
        n_chk++;
        if (ades0 !== 1'b1) begin
            n_err++; $display("FAIL sw_oor: got ades=%b want 1", ades0);
        end
        acc0(1'b0, 3'b000, 32'h2FFC, 32'h0);
        n_chk++;
        if (adel0 !== 1'b0 || rdata0 !== 32'h0) begin
            n_err++; $display("FAIL lw_last_word: got adel=%b rd=%h want 0 0", adel0, rdata0);
        end
        acc0(1'b0, 3'b101, 32'h10, 32'h0);
        n_chk++;
        if (adel0 !== 1'b1 || rdata0 !== 32'h0) begin
            n_err++; $display("FAIL reserved_mode: got adel=%b rd=%h want 1 0", adel0, rdata0);
        end
    endtask

    task automatic test_back_to_back();
        req0 = 1'b1; we0 = 1'b1; mode0 = 3'b000; addr0 = 32'h40; wdata0 = 32'hA5A5_0001;
        @(posedge clk); #1;
        addr0 = 32'h44; wdata0 = 32'h5A5A_0002;
        n_chk++;
        if (ready0 !== 1'b1) begin
            n_err++; $display("FAIL b2b_first: got %b want 1", ready0);
        end
        @(posedge clk); #1;
        req0 = 1'b0; we0 = 1'b0;
        n_chk++;
        if (ready0 !== 1'b1 || ades0 !== 1'b0) begin
            n_err++; $display("FAIL b2b_second: got rdy=%b ades=%b want 1 0", ready0, ades0);
        end
        acc0(1'b0, 3'b000, 32'h40, 32'h0);
        n_chk++;
        if (rdata0 !== 32'hA5A5_0001) begin
            n_err++; $display("FAIL b2b_rd40: got %h want a5a50001", rdata0);
        end
        acc0(1'b0, 3'b000, 32'h44, 32'h0);
        n_chk++;
        if (rdata0 !== 32'h5A5A_0002) begin
            n_err++; $display("FAIL b2b_rd44: got %h want 5a5a0002", rdata0);
        end
    endtask

    task automatic test_latency();
        logic [31:0] d;
        int lat;
        req1 = 1'b1; we1 = 1'b1; mode1 = 3'b000; addr1 = 32'h4; wdata1 = 32'h1234_5678;
        @(posedge clk); #1;
        req1 = 1'b0; we1 = 1'b0;
        n_chk++;
        if (ready1 !== 1'b1 || busy1 !== 1'b0) begin
            n_err++; $display("FAIL u1_sw: got rdy=%b busy=%b want 1 0", ready1, busy1);
        end
        req1 = 1'b1; we1 = 1'b0; mode1 = 3'b000; addr1 = 32'h4;
        @(posedge clk); #1;
        n_chk++;
        if (busy1 !== 1'b1 || ready1 !== 1'b0) begin
            n_err++; $display("FAIL lat_t1: got busy=%b rdy=%b want 1 0", busy1, ready1);
        end
        we1 = 1'b1; addr1 = 32'h8; wdata1 = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req1 = 1'b0; we1 = 1'b0;
        n_chk++;
        if (busy1 !== 1'b1 || ready1 !== 1'b0) begin
            n_err++; $display("FAIL lat_t2: got busy=%b rdy=%b want 1 0", busy1, ready1);
        end
        @(posedge clk); #1;
        n_chk++;
        if (busy1 !== 1'b0 || ready1 !== 1'b1 || rdata1 !== 32'h1234_5678) begin
            n_err++; $display("FAIL lat_t3: got busy=%b rdy=%b rd=%h want 0 1 12345678", busy1, ready1, rdata1);
        end
        ld1(3'b000, 32'h8, d, lat);
        n_chk++;
        if (d !== 32'h0 || lat !== 3) begin
            n_err++; $display("FAIL ignored_store: got rd=%h lat=%0d want 0 3", d, lat);
        end
        ld1(3'b011, 32'h6, d, lat);
        n_chk++;
        if (d !== 32'h0000_0034 || lat !== 3) begin
            n_err++; $display("FAIL u1_lb_0x6: got rd=%h lat=%0d want 00000034 3", d, lat);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        int lat;
        int seen;
        req1 = 1'b1; we1 = 1'b1; mode1 = 3'b000; addr1 = 32'hC; wdata1 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        we1 = 1'b0;
        @(posedge clk); #1;
        req1 = 1'b0; reset1 = 1'b1;
        n_chk++;
        if (busy1 !== 1'b1) begin
            n_err++; $display("FAIL abort_busy: got %b want 1", busy1);
        end
        @(posedge clk); #1;
        reset1 = 1'b0;
        n_chk++;
        if (busy1 !== 1'b0 || ready1 !== 1'b0) begin
            n_err++; $display("FAIL abort_state: got busy=%b rdy=%b want 0 0", busy1, ready1);
        end
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready1 === 1'b1) seen++;
        end
        n_chk++;
        if (seen !== 0) begin
            n_err++; $display("FAIL abort_no_ready: got %0d pulses want 0", seen);
        end
        for (int i = 0; i < 64; i++) begin
            ld1(3'b000, 32'(i * 4), d, lat);
            n_chk++;
            if (d !== 32'h0 || lat !== 3) begin
                n_err++; $display("FAIL cleared_word%0d: got rd=%h lat=%0d want 0 3", i, d, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_lane_merge();
        test_exceptions();
        test_back_to_back();
        test_latency();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
